// File: rtl/alpha_pmod_pkg.sv
// Shared constants and types for the ALPHA PMOD nybble link (receiver and transmitter sides).
package alpha_pmod_pkg;

    localparam int unsigned NYBBLE_WIDTH     = 4;
    localparam int unsigned NYBBLES_PER_WORD = 4;
    localparam int unsigned WORD_WIDTH       = 16;

    localparam logic [15:0] DEFAULT_HEADER_WORD = 16'hA1FA;
    localparam logic [15:0] DEFAULT_FOOTER_WORD = 16'hF00F;

    typedef enum logic [1:0] {HsSyncLow, HsWaitHigh, HsAckHigh} hs_state_e;
    typedef enum logic {FrSeek, FrFrame} frame_state_e;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/pmod_handshake_rx.sv
// PMOD input synchronizers and 4-phase handshake FSM; emits one pulse per captured nybble.
// ALPHA_PMOD_RECEIVER_TIMEOUT_EN adds a partial-word idle timeout.
module pmod_handshake_rx
    import alpha_pmod_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clock100,
    input  logic                    reset,
    input  logic [NYBBLE_WIDTH-1:0] pmod_data,
    input  logic                    pmod_strobe,
    input  logic                    stall_i,
    output logic                    acknowledge,
    output logic [NYBBLE_WIDTH-1:0] nybble_o,
    output logic                    nybble_strobe_o,
    output logic                    nybble_last_o,
    output logic                    timeout_o
);

    // Synchronizers keep sampling through reset so SYNC_LOW sees the true strobe level.
    logic                    s1_strobe_q, s2_strobe_q;
    logic [NYBBLE_WIDTH-1:0] s1_data_q, s2_data_q;

    always_ff @(posedge clock100) begin
        s1_strobe_q <= pmod_strobe;
        s2_strobe_q <= s1_strobe_q;
        s1_data_q   <= pmod_data;
        s2_data_q   <= s1_data_q;
    end

    hs_state_e               state_q;
    logic [1:0]              count_q;
    logic [NYBBLE_WIDTH-1:0] nybble_q;
    logic                    ack_q, strobe_q, last_q, timeout_q;
    logic                    timeout_hit;

`ifdef ALPHA_PMOD_RECEIVER_TIMEOUT_EN
    localparam int unsigned TimerWidth = $clog2(TIMEOUT_CYCLES + 1);
    logic [TimerWidth-1:0] timer_q;
    logic                  idle;

    // Only a quiet link counts as idle; a stalled (strobe-high) nybble must not expire.
    assign idle        = (state_q == HsWaitHigh) && (count_q != 2'd0) && !s2_strobe_q;
    assign timeout_hit = idle && (timer_q == TimerWidth'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock100) begin
        if (reset || !idle || timeout_hit) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TimerWidth'(1);
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clock100) begin
        if (reset) begin
            state_q   <= HsSyncLow;
            count_q   <= 2'd0;
            nybble_q  <= '0;
            ack_q     <= 1'b0;
            strobe_q  <= 1'b0;
            last_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            strobe_q  <= 1'b0;
            last_q    <= 1'b0;
            timeout_q <= 1'b0;
            unique case (state_q)
                HsSyncLow: begin
                    if (!s2_strobe_q) state_q <= HsWaitHigh;
                end
                HsWaitHigh: begin
                    if (s2_strobe_q && !(count_q == 2'd3 && stall_i)) begin
                        nybble_q <= s2_data_q;
                        strobe_q <= 1'b1;
                        last_q   <= (count_q == 2'd3);
                        count_q  <= count_q + 2'd1;
                        ack_q    <= 1'b1;
                        state_q  <= HsAckHigh;
                    end else if (timeout_hit) begin
                        count_q   <= 2'd0;
                        timeout_q <= 1'b1;
                    end
                end
                HsAckHigh: begin
                    if (!s2_strobe_q) begin
                        ack_q   <= 1'b0;
                        state_q <= HsWaitHigh;
                    end
                end
                default: state_q <= HsSyncLow;
            endcase
        end
    end

    assign acknowledge     = ack_q;
    assign nybble_o        = nybble_q;
    assign nybble_strobe_o = strobe_q;
    assign nybble_last_o   = last_q;
    assign timeout_o       = timeout_q;

endmodule

// File: rtl/alpha_pmod_receiver.sv
// PMOD nybble-link receiver: word assembly, output register, frame tracking and error counter.
// Optional partial-word timeout enabled by ALPHA_PMOD_RECEIVER_TIMEOUT_EN.
module alpha_pmod_receiver
    import alpha_pmod_pkg::*;
#(
    parameter logic [15:0] HEADER_WORD     = DEFAULT_HEADER_WORD,
    parameter logic [15:0] FOOTER_WORD     = DEFAULT_FOOTER_WORD,
    parameter int unsigned MAX_FRAME_WORDS = 4200,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic        clock100,
    input  logic        reset,
    input  logic [3:0]  pmod_data,
    input  logic        pmod_strobe,
    output logic        acknowledge,
    output logic [15:0] word,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        start_of_frame,
    output logic        end_of_frame,
    output logic [15:0] frame_word_count,
    output logic        in_frame,
    output logic [7:0]  error_count
);

    logic [NYBBLE_WIDTH-1:0] nybble;
    logic                    nybble_strobe, nybble_last, timeout;

    logic [WORD_WIDTH-1:0] word_q;
    logic                  valid_q, sof_q, eof_q, in_frame_q;
    logic [15:0]           count_q, fwc_q;
    logic [7:0]            err_q;
    logic [11:0]           shift_q;
    frame_state_e          fstate_q;

    pmod_handshake_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_handshake (
        .clock100       (clock100),
        .reset          (reset),
        .pmod_data      (pmod_data),
        .pmod_strobe    (pmod_strobe),
        .stall_i        (valid_q && !word_ready),
        .acknowledge    (acknowledge),
        .nybble_o       (nybble),
        .nybble_strobe_o(nybble_strobe),
        .nybble_last_o  (nybble_last),
        .timeout_o      (timeout)
    );

    logic [WORD_WIDTH-1:0] new_word;
    logic                  load, frame_err, hit_limit;

    assign new_word  = {shift_q, nybble};
    assign load      = nybble_strobe && nybble_last;
    assign hit_limit = (count_q + 16'd1) == 16'(MAX_FRAME_WORDS);
    // A footer always closes cleanly, even when it is the last word the limit allows.
    assign frame_err = load && ((fstate_q == FrSeek) ? (new_word != HEADER_WORD)
                                                    : (new_word != FOOTER_WORD &&
                                                       (new_word == HEADER_WORD || hit_limit)));

    always_ff @(posedge clock100) begin
        if (reset) begin
            shift_q <= '0;
        end else if (nybble_strobe) begin
            shift_q <= {shift_q[7:0], nybble};
        end
    end

    always_ff @(posedge clock100) begin
        if (reset) begin
            word_q     <= '0;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            in_frame_q <= 1'b0;
            count_q    <= '0;
            fwc_q      <= '0;
            err_q      <= '0;
            fstate_q   <= FrSeek;
        end else begin
            err_q <= sat_add8(err_q, {1'b0, frame_err} + {1'b0, timeout});
            if (valid_q && word_ready) begin
                valid_q <= 1'b0;
                sof_q   <= 1'b0;
                eof_q   <= 1'b0;
            end
            if (load) begin
                word_q  <= new_word;
                valid_q <= 1'b1;
                sof_q   <= 1'b0;
                eof_q   <= 1'b0;
                unique case (fstate_q)
                    FrSeek: begin
                        if (new_word == HEADER_WORD) begin
                            sof_q      <= 1'b1;
                            count_q    <= 16'd1;
                            in_frame_q <= 1'b1;
                            fstate_q   <= FrFrame;
                        end
                    end
                    FrFrame: begin
                        if (new_word == FOOTER_WORD) begin
                            eof_q      <= 1'b1;
                            fwc_q      <= count_q + 16'd1;
                            in_frame_q <= 1'b0;
                            fstate_q   <= FrSeek;
                        end else if (new_word == HEADER_WORD) begin
                            sof_q   <= 1'b1;
                            count_q <= 16'd1;
                        end else if (hit_limit) begin
                            in_frame_q <= 1'b0;
                            fstate_q   <= FrSeek;
                        end else begin
                            count_q <= count_q + 16'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign word             = word_q;
    assign word_valid       = valid_q;
    assign start_of_frame   = sof_q;
    assign end_of_frame     = eof_q;
    assign frame_word_count = fwc_q;
    assign in_frame         = in_frame_q;
    assign error_count      = err_q;

endmodule

// File: tb/tb_alpha_pmod_receiver.sv
// Randomized self-checking bench for alpha_pmod_receiver against a word/frame-level model.
module tb_alpha_pmod_receiver;

    localparam logic [15:0] HDR   = 16'hA1FA;
    localparam logic [15:0] FTR   = 16'hF00F;
    localparam int unsigned MAXW  = 12;
    localparam int          BOUND = 1000;

    logic        clock100 = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  pmod_data = 4'h0;
    logic        pmod_strobe = 1'b0;
    logic        acknowledge;
    logic [15:0] word;
    logic        word_valid;
    logic        word_ready = 1'b1;
    logic        start_of_frame, end_of_frame, in_frame;
    logic [15:0] frame_word_count;
    logic [7:0]  error_count;

    alpha_pmod_receiver #(
        .HEADER_WORD    (HDR),
        .FOOTER_WORD    (FTR),
        .MAX_FRAME_WORDS(MAXW),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clock100        (clock100),
        .reset           (reset),
        .pmod_data       (pmod_data),
        .pmod_strobe     (pmod_strobe),
        .acknowledge     (acknowledge),
        .word            (word),
        .word_valid      (word_valid),
        .word_ready      (word_ready),
        .start_of_frame  (start_of_frame),
        .end_of_frame    (end_of_frame),
        .frame_word_count(frame_word_count),
        .in_frame        (in_frame),
        .error_count     (error_count)
    );

    always #5 clock100 = ~clock100;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: words as the receiver must present them, plus frame/error bookkeeping.
    typedef struct packed {logic [15:0] w; logic sof; logic eof;} exp_t;
    exp_t        expq[$];
    logic [15:0] m_acc = '0;
    int          m_nyb = 0;
    bit          m_frame = 0;
    int          m_cnt = 0;
    int          m_err = 0;
    int          m_fwc = 0;

    function void model_word(input logic [15:0] w);
        exp_t e;
        e = '{w: w, sof: 1'b0, eof: 1'b0};
        if (!m_frame) begin
            if (w == HDR) begin e.sof = 1'b1; m_frame = 1; m_cnt = 1; end
            else m_err++;
        end else begin
            m_cnt++;
            if (w == FTR) begin e.eof = 1'b1; m_fwc = m_cnt; m_frame = 0; end
            else if (w == HDR) begin e.sof = 1'b1; m_err++; m_cnt = 1; end
            else if (m_cnt == MAXW) begin m_err++; m_frame = 0; end
        end
        if (m_err > 255) m_err = 255;
        expq.push_back(e);
    endfunction

    function void model_reset();
        expq.delete();
        m_acc = '0; m_nyb = 0; m_frame = 0; m_cnt = 0; m_err = 0; m_fwc = 0;
    endfunction

    initial begin
        forever begin
            @(negedge clock100);
            if (!reset && word_valid && word_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_word", {14'b0, word, start_of_frame, end_of_frame}, 32'hDEAD);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("word_sof_eof", {14'b0, word, start_of_frame, end_of_frame},
                        {14'b0, e.w, e.sof, e.eof});
                end
            end
        end
    end

    bit rand_ready = 0;
    initial begin
        forever begin
            @(posedge clock100);
            #1;
            if (rand_ready) word_ready = 1'($urandom_range(0, 1));
        end
    end

    int last_rise, last_fall;

    // Task entry/exit is always 1 time unit after a rising edge.
    task automatic send_nybble(input logic [3:0] n, input int hold, input int gap);
        int lat;
        pmod_data = n;
        @(posedge clock100); #1;
        pmod_strobe = 1'b1;
        lat = 0;
        while (lat < BOUND && !acknowledge) begin @(posedge clock100); #1; lat++; end
        last_rise = lat;
        if (!acknowledge) begin
            chk("ack_rise_timeout", 32'(lat), 32'(BOUND + 1));
        end else begin
            m_acc = {m_acc[11:0], n};
            m_nyb++;
            if (m_nyb == 4) begin model_word(m_acc); m_nyb = 0; end
        end
        repeat (hold) @(posedge clock100);
        #1;
        pmod_strobe = 1'b0;
        lat = 0;
        while (lat < BOUND && acknowledge) begin @(posedge clock100); #1; lat++; end
        last_fall = lat;
        if (acknowledge) chk("ack_fall_timeout", 32'(lat), 32'(BOUND + 1));
        repeat (gap) @(posedge clock100);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w, input int gap);
        for (int i = 3; i >= 0; i--) send_nybble(w[4*i +: 4], 0, gap);
    endtask

    task automatic drain_and_status();
        int t;
        rand_ready = 0;
        word_ready = 1'b1;
        t = 0;
        while (t < 500 && (expq.size() != 0 || word_valid)) begin @(posedge clock100); #1; t++; end
        chk("drain_words_left", 32'(expq.size()), 32'd0);
        chk("error_count", 32'(error_count), 32'(m_err));
        chk("frame_word_count", 32'(frame_word_count), 32'(m_fwc));
        chk("in_frame", 32'(in_frame), 32'(m_frame));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        int t;
        repeat (4) @(posedge clock100);
        #1;
        chk("rst_ack", 32'(acknowledge), 0);
        chk("rst_valid_word", {15'b0, word_valid, word}, 0);
        chk("rst_flags", {29'b0, start_of_frame, end_of_frame, in_frame}, 0);
        chk("rst_counts", {8'b0, error_count, frame_word_count}, 0);
        reset = 1'b0;
        repeat (3) @(posedge clock100);
        #1;

        // Basic frame with handshake latency checks and a long-held strobe.
        send_nybble(4'hA, 0, 1);
        chk("ack_rise_latency", 32'(last_rise), 3);
        chk("ack_fall_latency", 32'(last_fall), 3);
        send_nybble(4'h1, 50, 1);
        chk("ack_rise_latency_hold", 32'(last_rise), 3);
        chk("ack_fall_latency_hold", 32'(last_fall), 3);
        send_nybble(4'hF, 0, 1);
        send_nybble(4'hA, 0, 1);
        for (int i = 0; i < 6; i++) send_word(16'h1000 + 16'(i * 16'h0111), 1);
        send_word(FTR, 1);
        drain_and_status();
        chk("frame1_fwc_literal", 32'(frame_word_count), 8);
        chk("frame1_err_literal", 32'(error_count), 0);

        // Errors in SEEK and on a repeated header.
        send_word(16'h0001, 1);
        drain_and_status();
        chk("seek_err_literal", 32'(error_count), 1);
        send_word(HDR, 1);
        send_word(HDR, 1);
        drain_and_status();
        chk("dup_hdr_err_literal", 32'(error_count), 2);
        chk("dup_hdr_in_frame", 32'(in_frame), 1);

        // Backpressure: last nybble of second word must stall.
        word_ready = 1'b0;
        fork
            begin
                send_word(16'h1234, 1);
                send_word(16'h5678, 1);
            end
        join_none
        repeat (150) @(posedge clock100);
        #1;
        chk("stall_strobe_high", 32'(pmod_strobe), 1);
        chk("stall_no_ack", 32'(acknowledge), 0);
        chk("stall_held_word", {15'b0, word_valid, word}, {15'b0, 1'b1, 16'h1234});
        word_ready = 1'b1;
        wait fork;
        drain_and_status();

        // Partial word followed by a long idle gap.
        send_nybble(4'h1, 0, 1);
        send_nybble(4'h2, 0, 1);
        repeat (1100) @(posedge clock100);
        #1;
`ifdef ALPHA_PMOD_RECEIVER_TIMEOUT_EN
        m_nyb = 0;
        m_err++;
        send_word(16'h3456, 1);
`else
        send_nybble(4'h3, 0, 1);
        send_nybble(4'h4, 0, 1);
`endif
        drain_and_status();

        // Randomized traffic with random backpressure.
        rand_ready = 1;
        for (int i = 0; i < 80; i++) begin
            t = $urandom_range(0, 99);
            w = (t < 15) ? HDR : (t < 30) ? FTR : 16'($urandom);
            for (int k = 3; k >= 0; k--) send_nybble(w[4*k +: 4], 0, $urandom_range(0, 3));
        end
        drain_and_status();

        // Reset while strobe high and acknowledged.
        pmod_data = 4'h9;
        @(posedge clock100); #1;
        pmod_strobe = 1'b1;
        t = 0;
        while (t < BOUND && !acknowledge) begin @(posedge clock100); #1; t++; end
        chk("pre_reset_ack", 32'(acknowledge), 1);
        reset = 1'b1;
        @(posedge clock100); #1;
        chk("reset_ack_drop", 32'(acknowledge), 0);
        reset = 1'b0;
        model_reset();
        repeat (20) @(posedge clock100);
        #1;
        chk("post_reset_no_ack", 32'(acknowledge), 0);
        chk("post_reset_no_word", 32'(word_valid), 0);
        pmod_strobe = 1'b0;
        repeat (5) @(posedge clock100);
        #1;
        send_word(HDR, 1);
        send_word(FTR, 1);
        drain_and_status();
        chk("post_reset_fwc_literal", 32'(frame_word_count), 2);
        chk("post_reset_err_literal", 32'(error_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alpha_pmod_receiver.md
Name: alpha_pmod_receiver

Overview:
- Far-end receiver for the 5-wire PMOD nybble link that ships ALPHA readout data off the althea board: pmod_data[3:0] plus pmod_strobe, answered by acknowledge.
- Runs on a separate board in the clock100 domain and treats all PMOD inputs as asynchronous.
- Completes a 4-phase handshake per nybble, reassembles 16-bit words most-significant nybble first, and marks frame boundaries (header/footer).
- Presents words on a valid/ready stream to downstream logic (UART/USB bridge or capture RAM).

Parameters:
HEADER_WORD, 16'hA1FA, word value that opens a frame
FOOTER_WORD, 16'hF00F, word value that closes a frame
MAX_FRAME_WORDS, 4200, frame length limit in words, header and footer included
TIMEOUT_CYCLES, 1024, idle clock100 cycles before a partial word is discarded (optional feature only)

Ports:
clock100  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high
pmod_data  in  4  asynchronous nybble from transmitter
pmod_strobe  in  1  asynchronous request; high means pmod_data is valid
acknowledge  out  1  4-phase acknowledge back to transmitter
word  out  16  assembled word
word_valid  out  1  word holds unconsumed data
word_ready  in  1  downstream accepts word
start_of_frame  out  1  qualifies word: word is a header that opens a frame
end_of_frame  out  1  qualifies word: word is a footer that closes a frame
frame_word_count  out  16  word count of the last completed frame, latched at footer
in_frame  out  1  frame currently open
error_count  out  8  saturating framing/protocol error counter

Behaviour:
- Reset values: all outputs 0; handshake FSM in SYNC_LOW; frame FSM in SEEK; nybble_count 0.
- Sync: pmod_strobe and pmod_data each pass through 2 flops (s2 = synchronized strobe). Data is stable while strobe is high, so data_sync is valid whenever s2=1.
- Handshake FSM:
  - SYNC_LOW: wait for s2=0, then go to WAIT_HIGH. Prevents capturing a stale nybble when reset lands mid-phase.
  - WAIT_HIGH: on s2=1, if nybble_count==3 and word_valid and !word_ready, stall: hold ack=0 and stay. Otherwise shift data_sync in, nybble_count+1 mod 4, acknowledge<=1, go to ACK_HIGH.
  - ACK_HIGH: on s2=0, acknowledge<=0, go to WAIT_HIGH.
- Latency:
  - pmod_strobe rise to acknowledge rise: 3 clock100 edges.
  - strobe fall to ack fall: 3 edges.
  - 4th nybble capture to word_valid: 1 edge.
- Output register:
  - word, word_valid, start_of_frame and end_of_frame load together on 4th-nybble capture.
  - The word is consumed on word_valid & word_ready.
  - A load and a consume in the same cycle is legal: the new word replaces the old one and word_valid stays 1.
- Frame FSM, evaluated at word load:
  - SEEK, word==HEADER_WORD: start_of_frame=1, count=1, in_frame=1, go to FRAME.
  - SEEK, any other word: error+1; the word is still output with no flags.
  - FRAME: count+1 on every word.
  - FRAME, word==FOOTER_WORD: end_of_frame=1, frame_word_count<=count+1, in_frame=0, go to SEEK.
  - FRAME, word==HEADER_WORD: error+1, start_of_frame=1, count restarts at 1.
  - FRAME, count+1==MAX_FRAME_WORDS without footer: error+1, in_frame=0, go to SEEK.
- error_count saturates at 255; it never wraps.
- Reset mid-word: any partial nybbles are discarded and acknowledge drops on the next edge.

Optional Feature:
- Macro: ALPHA_PMOD_RECEIVER_TIMEOUT_EN.
- Defined:
  - A counter runs while in WAIT_HIGH with nybble_count!=0, and clears on each capture.
  - When it reaches TIMEOUT_CYCLES: nybble_count<=0, error+1, counter cleared. Frame state is unchanged.
- Undefined: no counter; partial words wait indefinitely.

Decomposition:
- Package alpha_pmod_pkg holds NYBBLE_WIDTH=4, NYBBLES_PER_WORD=4, WORD_WIDTH=16, and the default header/footer constants shared with the transmitter side.
- One natural sub-module, pmod_handshake_rx: synchronizers plus the 4-phase FSM and stall input. It outputs nybble[3:0] and a 1-cycle nybble_strobe.
- The top level does word assembly, the output register, the frame FSM and the error counter.

Test Plan:
- Send nybbles A,1,F,A, then 6 payload words, then F,0,0,F, with word_ready=1 → word 16'hA1FA with start_of_frame=1; 6 plain words; 16'hF00F with end_of_frame=1; frame_word_count=8; error_count=0.
- Measure each handshake → acknowledge rises exactly 3 edges after pmod_strobe rises and falls 3 edges after it falls; no second capture while strobe is held high for 50 cycles.
- Hold word_ready=0 and send 8 nybbles → the 2nd word's last nybble is not acknowledged; releasing word_ready delivers 16'h1234, then 16'h5678, with nothing lost.
- Send word 16'h0001 while in SEEK → error_count=1, no flags. Send header, header → error_count=2, second header flagged start_of_frame.
- Assert reset while pmod_strobe is high and acknowledge=1 → acknowledge=0 next edge; no capture until strobe goes low and high again.
- With the macro defined, send 2 nybbles then idle 1024 cycles → error_count+1; the next 4 nybbles assemble correctly. Without the macro, the same stimulus completes the word from the old 2 nybbles plus 2 new ones.
